// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared MSI snoop bus.
// Grants one cache, broadcasts its message, holds a snoop window, then runs any writeback.
module snoop_bus_arbiter #(
    parameter int N            = 4,
    parameter int IDW          = 2,
    parameter int SNOOP_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic [2*N-1:0]   msg_in_i,
    input  logic [N-1:0]     wb_req_i,
    input  logic             wb_done_i,
    output logic [N-1:0]     grant_o,
    output logic             bus_valid_o,
    output logic [1:0]       bus_msg_o,
    output logic [IDW-1:0]   bus_owner_o,
    output logic [N-1:0]     wb_grant_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             protocol_err_o
);

    localparam int CW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCAST,
        S_SNOOP,
        S_WB,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [1:0]     msg_q, msg_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           perr_q, perr_d;

    logic           found;
    logic [IDW-1:0] win;
    logic [1:0]     win_msg;
    int             idx;
    logic [N-1:0]   own_oh;
    logic [N-1:0]   pend_low;
    logic           pend_multi;

    assign own_oh     = N'(1) << owner_q;
    assign pend_low   = pend_q & (~pend_q + N'(1));
    assign pend_multi = |(pend_q & (pend_q - N'(1)));

    // Scan ptr, ptr+1, ... wrapping; the first eligible port wins.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_msg = 2'b00;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx] && (msg_in_i[2*idx +: 2] != 2'b00)) begin
                found   = 1'b1;
                win     = IDW'(idx);
                win_msg = msg_in_i[2*idx +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        msg_d   = msg_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = win;
                    msg_d   = win_msg;
                    pend_d  = '0;
                    state_d = S_BCAST;
                end
            end
            S_BCAST: begin
                cnt_d   = CW'(SNOOP_CYCLES - 1);
                state_d = S_SNOOP;
            end
            S_SNOOP: begin
                // Invalidates only hit shared copies, so no writeback can be owed.
                if (msg_q != 2'b11) pend_d = pend_q | (wb_req_i & ~own_oh);
                if (cnt_q == '0) begin
                    state_d = (pend_d != '0) ? S_WB : S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WB: begin
                if (pend_multi) perr_d = 1'b1;
                if (wb_done_i) state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            msg_q   <= 2'b00;
            pend_q  <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            msg_q   <= msg_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    logic owning;
    assign owning = (state_q == S_BCAST) || (state_q == S_SNOOP) || (state_q == S_WB);

    assign grant_o        = owning ? own_oh : '0;
    assign bus_valid_o    = (state_q == S_BCAST);
    assign bus_msg_o      = (state_q != S_IDLE) ? msg_q : 2'b00;
    assign bus_owner_o    = (state_q != S_IDLE) ? owner_q : '0;
    assign wb_grant_o     = (state_q == S_WB) ? pend_low : '0;
    assign done_o         = (state_q == S_DONE);
    assign busy_o         = (state_q != S_IDLE);
    assign protocol_err_o = perr_q | ((state_q == S_WB) && pend_multi);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Testbench for snoop_bus_arbiter: vector table, scoreboard of broadcasts,
// and hand sequences for timing, writeback and asynchronous reset.
module tb_snoop_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] msg;
    logic [3:0] wbr;
    logic       wb_done;
    logic [3:0] grant_o;
    logic       bus_valid_o;
    logic [1:0] bus_msg_o;
    logic [1:0] bus_owner_o;
    logic [3:0] wb_grant_o;
    logic       done_o;
    logic       busy_o;
    logic       protocol_err_o;

    always #5 clk = ~clk;

    snoop_bus_arbiter #(.N(4), .IDW(2), .SNOOP_CYCLES(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .msg_in_i      (msg),
        .wb_req_i      (wbr),
        .wb_done_i     (wb_done),
        .grant_o       (grant_o),
        .bus_valid_o   (bus_valid_o),
        .bus_msg_o     (bus_msg_o),
        .bus_owner_o   (bus_owner_o),
        .wb_grant_o    (wb_grant_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .protocol_err_o(protocol_err_o)
    );

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [1:0] own;
        logic [1:0] msg;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;
    bit  prev_done = 1'b0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] msg;
        logic [3:0] wbr;
        logic [1:0] own;
        logic [1:0] bmsg;
        logic       wb;
        logic [3:0] wbg;
        logic       perr;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({grant_o, bus_valid_o, bus_msg_o, bus_owner_o,
                    wb_grant_o, done_o, busy_o, protocol_err_o});
    endfunction

    // Every broadcast must match the oldest expected grant.
    always @(negedge clk) begin
        if (bus_valid_o) begin
            chk("idle_gap", 32'(prev_done), 32'd0);
            if (sbq.size() == 0) begin
                chk("sb_unexpected_bcast", 32'd1, 32'd0);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_owner", 32'(bus_owner_o), 32'(sb_e.own));
                chk("sb_msg", 32'(bus_msg_o), 32'(sb_e.msg));
                chk("sb_grant", 32'(grant_o), 32'(4'b0001 << sb_e.own));
            end
        end
        prev_done = done_o;
    end

    task automatic run_txn(input vec_t v, input string nm);
        bit saw_wb   = 1'b0;
        bit got_done = 1'b0;
        int wbc      = 0;
        sbq.push_back('{own: v.own, msg: v.bmsg});
        req = v.req;
        msg = v.msg;
        wbr = v.wbr;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            wb_done = 1'b0;
            if (wb_grant_o != 4'b0000) begin
                if (!saw_wb) begin
                    saw_wb = 1'b1;
                    chk({nm, "_wbg"}, 32'(wb_grant_o), 32'(v.wbg));
                    chk({nm, "_perr_wb"}, 32'(protocol_err_o), 32'(v.perr));
                end
                wbc++;
                if (wbc == 3) wb_done = 1'b1;
            end
            if (done_o) begin
                got_done = 1'b1;
                chk({nm, "_perr_done"}, 32'(protocol_err_o), 32'(v.perr));
            end
        end
        chk({nm, "_done"}, 32'(got_done), 32'd1);
        chk({nm, "_wb_state"}, 32'(saw_wb), 32'(v.wb));
        req     = 4'b0000;
        msg     = 8'h00;
        wbr     = 4'b0000;
        wb_done = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int n;
        tbl[0] = '{4'b0001, 8'h03, 4'b0100, 2'd0, 2'b11, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0001, 8'h02, 4'b0001, 2'd0, 2'b10, 1'b0, 4'b0000, 1'b0};
        tbl[2] = '{4'b1000, 8'h40, 4'b0001, 2'd3, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[3] = '{4'b1010, 8'h88, 4'b0000, 2'd1, 2'b10, 1'b0, 4'b0000, 1'b0};
        tbl[4] = '{4'b1010, 8'h88, 4'b0000, 2'd3, 2'b10, 1'b0, 4'b0000, 1'b0};
        tbl[5] = '{4'b0011, 8'h04, 4'b0000, 2'd1, 2'b01, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{4'b0001, 8'h02, 4'b0110, 2'd0, 2'b10, 1'b1, 4'b0010, 1'b1};
        tbl[7] = '{4'b0100, 8'h10, 4'b0000, 2'd2, 2'b01, 1'b0, 4'b0000, 1'b1};

        rst     = 1'b1;
        req     = 4'b0000;
        msg     = 8'h00;
        wbr     = 4'b0000;
        wb_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", all_outs(), 32'd0);

        // Single readMiss from port 0: exact cycle timeline.
        sbq.push_back('{own: 2'd0, msg: 2'b01});
        req = 4'b0001;
        msg = 8'h01;
        @(negedge clk);
        chk("t1_bvalid", 32'(bus_valid_o), 32'd1);
        chk("t1_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("t1_snoop_a", 32'({bus_valid_o, grant_o, done_o}), 32'({1'b0, 4'b0001, 1'b0}));
        @(negedge clk);
        chk("t1_snoop_b", 32'({grant_o, done_o}), 32'({4'b0001, 1'b0}));
        @(negedge clk);
        chk("t1_done", 32'({done_o, grant_o, bus_msg_o, bus_owner_o}),
            32'({1'b1, 4'b0000, 2'b01, 2'd0}));
        req = 4'b0000;
        msg = 8'h00;
        @(negedge clk);
        chk("t1_idle", 32'({busy_o, done_o, bus_msg_o}), 32'd0);

        // Pointer advanced to 1: port 1 beats port 0.
        run_txn('{4'b0011, 8'h0A, 4'b0000, 2'd1, 2'b10, 1'b0, 4'b0000, 1'b0}, "ptr1");

        // All four requesting from pointer 0: served 0,1,2,3,0.
        do_reset();
        sbq.push_back('{own: 2'd0, msg: 2'b10});
        sbq.push_back('{own: 2'd1, msg: 2'b10});
        sbq.push_back('{own: 2'd2, msg: 2'b10});
        sbq.push_back('{own: 2'd3, msg: 2'b10});
        sbq.push_back('{own: 2'd0, msg: 2'b10});
        req = 4'b1111;
        msg = 8'hAA;
        n   = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            @(negedge clk);
            if (done_o) n++;
            if (n == 5) req = 4'b0000;
        end
        req = 4'b0000;
        msg = 8'h00;
        chk("rr_done_count", 32'(n), 32'd5);
        chk("rr_sb_drained", 32'(sbq.size()), 32'd0);
        @(negedge clk);

        // Owner 2, writeback request only in the last snoop cycle.
        sbq.push_back('{own: 2'd2, msg: 2'b01});
        req = 4'b0100;
        msg = 8'h10;
        @(negedge clk);
        chk("v0_bvalid", 32'(bus_valid_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        wbr = 4'b0010;
        @(negedge clk);
        wbr = 4'b0000;
        chk("v0_wbg", 32'(wb_grant_o), 32'(4'b0010));
        chk("v0_perr", 32'(protocol_err_o), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_grant_o !== 4'b0010 || done_o !== 1'b0) ok = 1'b0;
        end
        chk("v0_wb_hold", 32'(ok), 32'd1);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
        chk("v0_done", 32'({done_o, wb_grant_o, protocol_err_o}), 32'({1'b1, 4'b0000, 1'b0}));
        req = 4'b0000;
        msg = 8'h00;
        @(negedge clk);
        chk("v0_idle", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        do_reset();
        chk("perr_cleared", 32'(protocol_err_o), 32'd0);

        // Asynchronous reset in the middle of a writeback.
        sbq.push_back('{own: 2'd0, msg: 2'b10});
        req = 4'b0001;
        msg = 8'h02;
        wbr = 4'b0010;
        ok  = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (wb_grant_o != 4'b0000) ok = 1'b1;
        end
        chk("ar_reached_wb", 32'(ok), 32'd1);
        #2;
        rst = 1'b1;
        req = 4'b0000;
        msg = 8'h00;
        wbr = 4'b0000;
        #1;
        chk("ar_async_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn('{4'b0100, 8'h10, 4'b0000, 2'd2, 2'b01, 1'b0, 4'b0000, 1'b0}, "ar_next");

        // A request carrying no message is never granted.
        req = 4'b0001;
        msg = 8'h00;
        ok  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy_o !== 1'b0) ok = 1'b0;
        end
        chk("msg00_ignored", 32'(ok), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Round-robin arbiter and sequencer for the shared snoop bus of the MSI coherence system. Each per-CPU cache controller raises a request carrying its bus message (readMiss, writeMiss, invalidate). The arbiter grants one requester, broadcasts its message to all snoopers, and holds a fixed snoop window. If a snooper holding the line exclusive must write it back, the arbiter runs that writeback before releasing the bus.

## Interface
- N, 4, number of CPU/cache ports (2..8)
- IDW, 2, owner-index width; 2^IDW >= N
- SNOOP_CYCLES, 2, length of snoop window in cycles (>= 1)

- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  reset, asynchronous, active-high
- req  in  N  bus request per cache, held high until its done pulse
- msg_in  in  2N  message per cache, bits [2i+1:2i]: 01 readMiss, 10 writeMiss, 11 invalidate, 00 none
- wb_req  in  N  snooper i holds the addressed line exclusive and must write back
- wb_done  in  1  one-cycle pulse from memory when the granted writeback completes
- grant  out  N  one-hot, current bus owner
- bus_valid  out  1  one-cycle broadcast strobe
- bus_msg  out  2  latched message of owner
- bus_owner  out  IDW  index of owner
- wb_grant  out  N  one-hot writeback grant
- done  out  1  one-cycle transaction-complete pulse
- busy  out  1  high in every state except IDLE
- protocol_err  out  1  sticky: multiple writeback requesters seen

## Operation
- States: IDLE, BCAST, SNOOP, WB, DONE.
- A port is eligible iff req[i]=1 and msg_in[i]≠00. A request with message 00 is ignored.
- Round-robin pointer ptr, reset 0. In IDLE, the winner is the first eligible index scanning ptr, ptr+1, …, N-1, 0, … (mod N).
- IDLE: if any port is eligible, latch winner→owner and msg_in[owner]→msg, clear wb_pending, go to BCAST. Otherwise stay in IDLE.
- BCAST, 1 cycle: bus_valid=1. Load snoop counter with SNOOP_CYCLES-1. Go to SNOOP.
- SNOOP: each cycle, OR wb_req & ~onehot(owner) into wb_pending.
  - Ignore wb_req entirely when msg=11 (invalidate targets shared copies only).
  - When the counter reaches 0: go to WB if wb_pending≠0, else go to DONE. Otherwise decrement.
- WB: wb_grant = lowest set bit of wb_pending. If more than one bit is set, set protocol_err, which stays set until Reset. On wb_done=1, go to DONE.
- DONE, 1 cycle: done=1, ptr←(owner+1) mod N, go to IDLE.
- grant=onehot(owner) in BCAST, SNOOP and WB; 0 in IDLE and DONE.
- bus_msg and bus_owner hold their latched values from BCAST through DONE; they are 0 in IDLE.
- A requester dropping req mid-transaction does not abort the transaction; it runs to DONE.
- A changing msg_in after latch has no effect.
- A wb_done outside WB is ignored.

## Timing
- Reset values: grant=0, bus_valid=0, bus_msg=00, bus_owner=0, wb_grant=0, done=0, busy=0, protocol_err=0, ptr=0, state IDLE.
- Reset asserted mid-transaction forces the reset values immediately (asynchronous) and discards the transaction.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Timeline for an eligible req in IDLE at edge k:
  - BCAST in cycle k+1.
  - SNOOP in cycles k+2 … k+1+SNOOP_CYCLES.
  - DONE in cycle k+2+SNOOP_CYCLES when no writeback is needed.
- With writeback: WB lasts until the edge sampling wb_done; DONE is the following cycle.
- Back-to-back transactions: at least one IDLE cycle between DONE and the next BCAST.
- Minimum bus occupancy is SNOOP_CYCLES+3 cycles per transaction.
- A wb_req present in the final SNOOP cycle is captured.

## Test plan
- Reset, then req=0001, msg_in[1:0]=01, SNOOP_CYCLES=2 -> bus_valid pulses 1 cycle after the sampling edge with bus_msg=01, bus_owner=0. grant=0001 for 3 cycles. done fires 4 cycles after the sampling edge. ptr=1.
- req=1111 with all messages 10, held high -> owners are served in order 0,1,2,3,0. Each done precedes the next BCAST by at least 1 IDLE cycle.
- Owner 2 broadcasting 01, wb_req=0010 pulsed in the last SNOOP cycle -> WB entered, wb_grant=0010. wb_done after 5 cycles -> DONE next cycle. protocol_err=0.
- Owner 0 broadcasting 11 with wb_req=0100 -> no WB state. done follows SNOOP directly. wb_grant stays 0.
- Owner 0 broadcasting 10 with wb_req=0110 -> wb_grant=0010 and protocol_err=1, which persists after DONE until Reset. wb_req=0001 (owner only) -> ignored.
- Reset asserted during WB -> all outputs return to the reset values without a clock edge. req=0100 then wins next with bus_owner=2. Separately, req=0001 with msg_in=00 -> stays in IDLE with busy=0.
